ibex_ascon_perm_ctrl: RTL
=========================

IBEX_ASCON_PERM_CTRL -- requirements
Module: ibex_ascon_perm_ctrl

Purpose: multi-cycle initiator for the combinational Ascon round datapath. It accepts p^a requests from the core, iterates the datapath ceil(a/UNROLLED_ROUNDS) times, and returns the 320-bit result.

Interface
REQ-001 The block SHALL have parameter UNROLLED_ROUNDS, default 1, giving the rounds per datapath pass; legal values are 1, 2, 3, 4 and 6.
REQ-002 The block SHALL have one clock and an asynchronous active-low reset:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
REQ-003 req_i  in  1  permutation request.
REQ-004 rounds_i  in  4  round count a; legal range 1..12.
REQ-005 state_i  in  320  input state, {x0,x1,x2,x3,x4} in register view, x0 in the MSBs.
REQ-006 gnt_o  out  1  request accepted this cycle.
REQ-007 valid_o  out  1  result available.
REQ-008 ready_i  in  1  consumer accepts the result.
REQ-009 state_o  out  320  result state, same layout as state_i.
REQ-010 err_o  out  1  illegal rounds_i; qualified by valid_o.
REQ-011 busy_o  out  1  FSM not in IDLE.
REQ-012 dp_en_o  out  1  datapath enable.
REQ-013 dp_state_o  out  320  datapath input state.
REQ-014 dp_rc_o  out  8  first round constant of the current pass.
REQ-015 dp_rounds_o  out  3  rounds in the current pass minus one.
REQ-016 dp_state_i  in  320  datapath output state.
REQ-017 perf_cycles_o  out  32  busy-cycle counter (see Configuration).

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 gnt_o SHALL equal req_i in IDLE, req_i & ready_i in DONE, and 0 in RUN.
REQ-020 On grant the block SHALL register state_i into st_q and rounds_i into a_q, and SHALL clear the done-round counter k_q to 0.
REQ-021 On grant with rounds_i in 1..12 the FSM SHALL enter RUN.
REQ-022 On grant with any other rounds_i, the FSM SHALL enter DONE with err_o=1 and state_o=state_i unchanged.
REQ-023 In RUN the step size SHALL be step = min(UNROLLED_ROUNDS, a_q-k_q).
REQ-024 In RUN the datapath outputs SHALL be:
- dp_en_o=1 and dp_state_o=st_q
- dp_rounds_o = step-1
- dp_rc_o = {h, ~h}, where h = 4-bit (a_q + 3 - k_q) mod 16
REQ-025 Each RUN cycle SHALL set st_q <= dp_state_i and k_q <= k_q+step.
REQ-026 When k_q+step == a_q the FSM SHALL go to DONE.
REQ-027 Outside RUN, dp_en_o SHALL be 0 and dp_state_o, dp_rc_o and dp_rounds_o SHALL be 0.
REQ-028 valid_o SHALL assert exactly ceil(a/UNROLLED_ROUNDS) cycles after the grant edge.
REQ-029 valid_o and state_o SHALL stay stable until ready_i is sampled high.
REQ-030 On valid_o & ready_i without req_i, the FSM SHALL go to IDLE.
REQ-031 On valid_o & ready_i with req_i, the block SHALL grant the new request in the same cycle (back-to-back, no bubble).
REQ-032 state_o SHALL equal st_q in DONE and 0 otherwise.
REQ-033 req_i in RUN SHALL be ignored; it is not queued.
REQ-034 k_q SHALL be 4 bits wide and SHALL never exceed a_q.

Reset
REQ-035 On rst_ni low, asynchronously: FSM=IDLE; st_q, a_q and k_q =0; every output =0, including perf_cycles_o.
REQ-036 Reset asserted mid-RUN SHALL abandon the permutation, and no valid_o SHALL follow after release.

Configuration
REQ-037 With macro IBEX_ASCON_PERM_PERF_EN defined, perf_cycles_o SHALL increment by 1 on every cycle busy_o=1.
REQ-038 The counter SHALL wrap from 0xFFFF_FFFF to 0 and SHALL be cleared only by reset.
REQ-039 Without IBEX_ASCON_PERM_PERF_EN, perf_cycles_o SHALL be constant 0 and no counter flops SHALL be synthesized.

Verification
REQ-040 U=1, p12 request, ready_i=1 -> dp_rc_o sequence F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B; valid_o 12 cycles after grant; state_o matches the software Ascon model.
REQ-041 U=1, rounds_i=8 then rounds_i=6 -> first dp_rc_o of each request is B4 and 96 respectively; valid_o after 8 and 6 cycles.
REQ-042 U=4, rounds_i=6 -> two passes with dp_rounds_o=3 then 1 and dp_rc_o=96 then 5A; valid_o after 2 cycles.
REQ-043 rounds_i=0 and rounds_i=13 -> valid_o 1 cycle after grant; err_o=1; state_o=state_i; dp_en_o never asserts.
REQ-044 Hold ready_i=0 for 5 cycles in DONE with req_i held high -> gnt_o=0 and state_o stable throughout; on ready_i=1 the new request is granted in the same cycle.
REQ-045 Assert rst_ni low at k_q=5 of a p12 -> outputs 0 immediately; no valid_o after release; perf_cycles_o=0; with IBEX_ASCON_PERM_PERF_EN defined, an uninterrupted U=1 p12 then gives perf_cycles_o=13.

Source files
------------

// File: rtl/ibex_ascon_perm_ctrl.sv
// Multi-cycle controller driving an external combinational Ascon round datapath.
// Optional busy-cycle counter enabled by macro IBEX_ASCON_PERM_PERF_EN.
module ibex_ascon_perm_ctrl #(
    parameter int unsigned UNROLLED_ROUNDS = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         req_i,
    input  logic [3:0]   rounds_i,
    input  logic [319:0] state_i,
    output logic         gnt_o,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [319:0] state_o,
    output logic         err_o,
    output logic         busy_o,
    output logic         dp_en_o,
    output logic [319:0] dp_state_o,
    output logic [7:0]   dp_rc_o,
    output logic [2:0]   dp_rounds_o,
    input  logic [319:0] dp_state_i,
    output logic [31:0]  perf_cycles_o
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

    localparam logic [3:0] U = 4'(UNROLLED_ROUNDS);

    fsm_e         fsm_q, fsm_d;
    logic [319:0] st_q;
    logic [3:0]   a_q, k_q;
    logic         err_q;
    logic         gnt, legal;
    logic [3:0]   rem, step, k_nxt, h;

    always_comb begin
        rem   = a_q - k_q;
        step  = (rem < U) ? rem : U;
        k_nxt = k_q + step;
        h     = a_q + 4'd3 - k_q;
        legal = (rounds_i != 4'd0) && (rounds_i <= 4'd12);
        fsm_d = fsm_q;
        gnt   = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                gnt = req_i;
                if (req_i) fsm_d = legal ? RUN : DONE;
            end
            RUN: begin
                if (k_nxt == a_q) fsm_d = DONE;
            end
            DONE: begin
                if (ready_i) begin
                    gnt   = req_i;
                    fsm_d = req_i ? (legal ? RUN : DONE) : IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q <= IDLE;
            st_q  <= '0;
            a_q   <= '0;
            k_q   <= '0;
            err_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            if (gnt) begin
                st_q  <= state_i;
                a_q   <= rounds_i;
                k_q   <= '0;
                err_q <= ~legal;
            end else if (fsm_q == RUN) begin
                st_q <= dp_state_i;
                k_q  <= k_nxt;
            end
        end
    end

    // gnt_o is forced low while reset is held so every output reads 0
    assign gnt_o       = gnt & rst_ni;
    assign busy_o      = (fsm_q != IDLE);
    assign valid_o     = (fsm_q == DONE);
    assign err_o       = valid_o & err_q;
    assign state_o     = valid_o ? st_q : '0;
    assign dp_en_o     = (fsm_q == RUN);
    assign dp_state_o  = dp_en_o ? st_q : '0;
    assign dp_rc_o     = dp_en_o ? {h, ~h} : 8'h00;
    assign dp_rounds_o = dp_en_o ? 3'(step - 4'd1) : 3'd0;

`ifdef IBEX_ASCON_PERM_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) perf_q <= '0;
        else if (busy_o) perf_q <= perf_q + 32'd1;
    end

    assign perf_cycles_o = perf_q;
`else
    assign perf_cycles_o = '0;
`endif

endmodule
